// File: rtl/code_breaker_pkg.sv
// Shared Mastermind constants, FSM state encoding and the history record layout.
package code_breaker_pkg;
   localparam int PEGS      = 4;
   localparam int COLOR_W   = 3;
   localparam int COLORS    = 1 << COLOR_W;
   localparam int MAX_TURNS = 8;
   localparam int SCORE_W   = 3;
   localparam int CAND_W    = PEGS * COLOR_W;
   localparam int TURN_W    = 4;
   localparam int IDX_W     = $clog2(MAX_TURNS);

   localparam logic [SCORE_W-1:0] ALL_BLACK = SCORE_W'(PEGS);
   localparam logic [SCORE_W:0]   MAX_SUM   = (SCORE_W+1)'(PEGS);
   localparam logic [TURN_W-1:0]  LAST_TURN = TURN_W'(MAX_TURNS - 1);

   typedef enum logic [2:0] {
      IDLE, SEARCH, PROPOSE, WAIT_FB, SOLVED, FAILED
   } state_t;

   typedef struct packed {
      logic [CAND_W-1:0]  code;
      logic [SCORE_W-1:0] black;
      logic [SCORE_W-1:0] white;
   } hist_t;
endpackage

// File: rtl/code_breaker_peg_scorer.sv
// Combinational black/white peg scorer; peg 0 occupies the low COLOR_W bits of each code.
module peg_scorer
   import code_breaker_pkg::*;
(
   input  logic [CAND_W-1:0]  code_a,
   input  logic [CAND_W-1:0]  code_b,
   output logic [SCORE_W-1:0] black,
   output logic [SCORE_W-1:0] white
);
   logic [PEGS-1:0]    hit;
   logic [SCORE_W-1:0] cnt_a, cnt_b, common;

   for (genvar p = 0; p < PEGS; p++) begin : g_peg
      assign hit[p] = code_a[p*COLOR_W +: COLOR_W] == code_b[p*COLOR_W +: COLOR_W];
   end

   // white = sum over colours of min(count_a, count_b), minus the exact hits
   always_comb begin
      black  = '0;
      common = '0;
      cnt_a  = '0;
      cnt_b  = '0;
      for (int p = 0; p < PEGS; p++)
         black = black + SCORE_W'(hit[p]);
      for (int c = 0; c < COLORS; c++) begin
         cnt_a = '0;
         cnt_b = '0;
         for (int p = 0; p < PEGS; p++) begin
            if (code_a[p*COLOR_W +: COLOR_W] == COLOR_W'(c)) cnt_a = cnt_a + SCORE_W'(1);
            if (code_b[p*COLOR_W +: COLOR_W] == COLOR_W'(c)) cnt_b = cnt_b + SCORE_W'(1);
         end
         common = common + ((cnt_a < cnt_b) ? cnt_a : cnt_b);
      end
      white = common - black;
   end
endmodule

// File: rtl/code_breaker.sv
// Automatic Mastermind codebreaker: proposes the lowest candidate consistent with all stored scores.
// Define SOLVER_SEED_EN to add a seed input that sets the starting candidate of each game.
module code_breaker
   import code_breaker_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
`ifdef SOLVER_SEED_EN
   input  logic [CAND_W-1:0]    seed,
`endif
   output logic [COLOR_W-1:0]   guess0,
   output logic [COLOR_W-1:0]   guess1,
   output logic [COLOR_W-1:0]   guess2,
   output logic [COLOR_W-1:0]   guess3,
   output logic                 guess_valid,
   input  logic                 guess_ready,
   input  logic                 fb_valid,
   input  logic [SCORE_W-1:0]   fb_black,
   input  logic [SCORE_W-1:0]   fb_white,
   output logic                 busy,
   output logic                 solved,
   output logic                 failed,
   output logic [TURN_W-1:0]    turn_count
);
   state_t             state;
   logic [CAND_W-1:0]  cand;
   logic [TURN_W-1:0]  idx;
   hist_t              hist [MAX_TURNS];
   hist_t              entry;
   logic [SCORE_W-1:0] sc_black, sc_white;
   logic [SCORE_W:0]   fb_sum;
   logic               match, wrap_fail, cand_end;

   assign entry  = hist[idx[IDX_W-1:0]];
   assign match  = (sc_black == entry.black) && (sc_white == entry.white);
   assign fb_sum = {1'b0, fb_black} + {1'b0, fb_white};

   peg_scorer u_scorer (
      .code_a (cand),
      .code_b (entry.code),
      .black  (sc_black),
      .white  (sc_white)
   );

`ifdef SOLVER_SEED_EN
   // Rejections since the last proposal; the 4096th means the whole space was tried.
   logic [CAND_W-1:0] rej;
   assign wrap_fail = &rej;
   assign cand_end  = 1'b0;
`else
   assign wrap_fail = &cand;
   assign cand_end  = &cand;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cand        <= '0;
         idx         <= '0;
         {guess3, guess2, guess1, guess0} <= '0;
         guess_valid <= 1'b0;
         busy        <= 1'b0;
         solved      <= 1'b0;
         failed      <= 1'b0;
         turn_count  <= '0;
         for (int i = 0; i < MAX_TURNS; i++) hist[i] <= '0;
`ifdef SOLVER_SEED_EN
         rej         <= '0;
`endif
      end else begin
         case (state)
            IDLE, SOLVED, FAILED: begin
               if (start) begin
                  state      <= SEARCH;
                  busy       <= 1'b1;
                  solved     <= 1'b0;
                  failed     <= 1'b0;
                  turn_count <= '0;
                  idx        <= '0;
                  for (int i = 0; i < MAX_TURNS; i++) hist[i] <= '0;
`ifdef SOLVER_SEED_EN
                  cand       <= seed;
                  rej        <= '0;
`else
                  cand       <= '0;
`endif
               end
            end
            SEARCH: begin
               if (idx == turn_count) begin
                  state       <= PROPOSE;
                  guess_valid <= 1'b1;
                  {guess3, guess2, guess1, guess0} <= cand;
`ifdef SOLVER_SEED_EN
                  rej         <= '0;
`endif
               end else if (match) begin
                  idx <= idx + TURN_W'(1);
               end else if (wrap_fail) begin
                  state  <= FAILED;
                  busy   <= 1'b0;
                  failed <= 1'b1;
               end else begin
                  cand <= cand + CAND_W'(1);
                  idx  <= '0;
`ifdef SOLVER_SEED_EN
                  rej  <= rej + CAND_W'(1);
`endif
               end
            end
            PROPOSE: begin
               if (guess_ready) begin
                  state       <= WAIT_FB;
                  guess_valid <= 1'b0;
               end
            end
            WAIT_FB: begin
               if (fb_valid) begin
                  if (fb_sum > MAX_SUM) begin
                     state  <= FAILED;
                     busy   <= 1'b0;
                     failed <= 1'b1;
                  end else begin
                     hist[turn_count[IDX_W-1:0]] <= {cand, fb_black, fb_white};
                     turn_count <= turn_count + TURN_W'(1);
                     if (fb_black == ALL_BLACK) begin
                        state  <= SOLVED;
                        busy   <= 1'b0;
                        solved <= 1'b1;
                     end else if (turn_count == LAST_TURN || cand_end) begin
                        state  <= FAILED;
                        busy   <= 1'b0;
                        failed <= 1'b1;
                     end else begin
                        state <= SEARCH;
                        cand  <= cand + CAND_W'(1);
                        idx   <= '0;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
